// File: rtl/fifo_pkg.sv
// Shared types and sizing for the 8-entry FIFO controller.
// State encoding, pointer/count widths and a one-hot helper.
package fifo_pkg;

   localparam int DEPTH = 8;
   localparam int PTR_W = 3;
   localparam int CNT_W = 4;

   typedef enum logic [2:0] {
      INIT     = 3'd0,
      NO_OP    = 3'd1,
      WRITE    = 3'd2,
      WR_ERROR = 3'd3,
      READ     = 3'd4,
      RD_ERROR = 3'd5
   } state_t;

   function automatic logic [DEPTH-1:0] onehot(
      input logic [PTR_W-1:0] p
   );
      logic [DEPTH-1:0] v;
      v = '0;
      v[p] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/fifo8_ctrl_if.sv
// Handshake/bus bundle between the FIFO controller and its user.
// master: requester and register bank side; slave: controller.
interface fifo8_ctrl_if #(
   parameter int DATA_W = 32
);
   import fifo_pkg::*;

   logic              wr_en;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic [DEPTH-1:0]  we;
   logic [PTR_W-1:0]  rd_ptr;
   logic [DATA_W-1:0] d_out;
   logic              full;
   logic              empty;
   logic              wr_ack;
   logic              wr_err;
   logic              rd_ack;
   logic              rd_err;
   logic [CNT_W-1:0]  data_count;

   modport master (
      output wr_en, rd_en, rd_data,
      input  we, rd_ptr, d_out, full, empty,
      input  wr_ack, wr_err, rd_ack, rd_err,
      input  data_count
   );

   modport slave (
      input  wr_en, rd_en, rd_data,
      output we, rd_ptr, d_out, full, empty,
      output wr_ack, wr_err, rd_ack, rd_err,
      output data_count
   );

endinterface

// File: rtl/fifo8_ctrl_ns.sv
// Next-state, next-pointer and next-count logic for fifo8_ctrl.
// Pure combinational; the top owns every register.
module fifo8_ctrl_ns
   import fifo_pkg::*;
(
   input  logic             wr_en,
   input  logic             rd_en,
   input  logic [PTR_W-1:0] head,
   input  logic [PTR_W-1:0] tail,
   input  logic [CNT_W-1:0] count,
   output state_t           state_d,
   output logic [PTR_W-1:0] head_d,
   output logic [PTR_W-1:0] tail_d,
   output logic [CNT_W-1:0] count_d,
   output logic             wr_acc,
   output logic             rd_acc
);

   logic is_full;
   logic is_empty;
   logic wr_only;
   logic rd_only;

   assign is_full  = (count == CNT_W'(DEPTH));
   assign is_empty = (count == '0);
   assign wr_only  = wr_en & ~rd_en;
   assign rd_only  = rd_en & ~wr_en;

   // Classify the request; only a lone, legal op moves state.
   always_comb begin
      state_d = NO_OP;
      head_d  = head;
      tail_d  = tail;
      count_d = count;
      wr_acc  = 1'b0;
      rd_acc  = 1'b0;
      unique case (1'b1)
         (wr_only & ~is_full): begin
            state_d = WRITE;
            tail_d  = tail + 1'b1;
            count_d = count + 1'b1;
            wr_acc  = 1'b1;
         end
         (wr_only & is_full): begin
            state_d = WR_ERROR;
         end
         (rd_only & ~is_empty): begin
            state_d = READ;
            head_d  = head + 1'b1;
            count_d = count - 1'b1;
            rd_acc  = 1'b1;
         end
         (rd_only & is_empty): begin
            state_d = RD_ERROR;
         end
         default: begin
            state_d = NO_OP;
         end
      endcase
   end

endmodule

// File: rtl/fifo8_ctrl.sv
// 8-entry FIFO controller: pointers, count and read register.
// Storage and the read mux live outside; we/rd_ptr drive them.
module fifo8_ctrl
   import fifo_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input logic         clk,
   input logic         reset_n,
   fifo8_ctrl_if.slave bus
);

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] d_out_q, d_out_d;
   logic              wr_acc;
   logic              rd_acc;

   fifo8_ctrl_ns u_ns (
      .wr_en   (bus.wr_en),
      .rd_en   (bus.rd_en),
      .head    (head_q),
      .tail    (tail_q),
      .count   (count_q),
      .state_d (state_d),
      .head_d  (head_d),
      .tail_d  (tail_d),
      .count_d (count_d),
      .wr_acc  (wr_acc),
      .rd_acc  (rd_acc)
   );

   // Capture the muxed bank word only on an accepted read.
   always_comb begin
      d_out_d = d_out_q;
      if (rd_acc) begin
         d_out_d = bus.rd_data;
      end
   end

   // Controller registers, cleared asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= INIT;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         d_out_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         d_out_q <= d_out_d;
      end
   end

   // Write strobe is gated by reset so the bank stays quiet in reset.
   assign bus.we = (wr_acc && reset_n) ? onehot(tail_q) : '0;

   assign bus.rd_ptr     = head_q;
   assign bus.d_out      = d_out_q;
   assign bus.full       = (count_q == CNT_W'(DEPTH));
   assign bus.empty      = (count_q == '0);
   assign bus.data_count = count_q;
   assign bus.wr_ack     = (state_q == WRITE);
   assign bus.wr_err     = (state_q == WR_ERROR);
   assign bus.rd_ack     = (state_q == READ);
   assign bus.rd_err     = (state_q == RD_ERROR);

endmodule

// File: tb/tb_fifo8_ctrl.sv
// Scoreboard bench for fifo8_ctrl with a behavioural 8x32 bank.
// Directed ops push expectations; a monitor pops and compares.
module tb_fifo8_ctrl;

   localparam logic [3:0] S_NONE = 4'b0000;
   localparam logic [3:0] S_WACK = 4'b1000;
   localparam logic [3:0] S_WERR = 4'b0100;
   localparam logic [3:0] S_RACK = 4'b0010;
   localparam logic [3:0] S_RERR = 4'b0001;

   typedef struct {
      logic [7:0]  we;
      logic [3:0]  st;
      logic [31:0] dout;
      logic [3:0]  cnt;
      string       tag;
   } exp_t;

   logic        clk;
   logic        reset_n;
   logic [31:0] d_in;
   logic [31:0] bank [8];
   int          checks;
   int          errors;
   exp_t        exp_q [$];

   fifo8_ctrl_if #(.DATA_W(32)) bus ();

   fifo8_ctrl #(.DATA_W(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Register bank and read mux the controller is built to drive.
   always @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (bus.we[i]) bank[i] <= d_in;
      end
   end

   assign bus.rd_data = bank[bus.rd_ptr];

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", n, act, req);
      end
   endtask

   // Monitor: we sampled before the edge, registered outputs after.
   initial begin
      exp_t        e;
      logic [7:0]  we_s;
      forever begin
         @(negedge clk);
         we_s = bus.we;
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.tag, " we"}, 32'(we_s), 32'(e.we));
            chk({e.tag, " status"},
                32'({bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err}),
                32'(e.st));
            chk({e.tag, " d_out"}, bus.d_out, e.dout);
            chk({e.tag, " count"}, 32'(bus.data_count), 32'(e.cnt));
            chk({e.tag, " full"}, 32'(bus.full), 32'(e.cnt == 4'd8));
            chk({e.tag, " empty"}, 32'(bus.empty), 32'(e.cnt == 4'd0));
         end
      end
   end

   task automatic op(input bit w, input bit r, input logic [31:0] d,
                     input logic [7:0] xwe, input logic [3:0] xst,
                     input logic [31:0] xdo, input logic [3:0] xcnt,
                     input string tag);
      exp_t e;
      @(posedge clk);
      #2;
      bus.wr_en = w;
      bus.rd_en = r;
      d_in      = d;
      e.we   = xwe;
      e.st   = xst;
      e.dout = xdo;
      e.cnt  = xcnt;
      e.tag  = tag;
      exp_q.push_back(e);
   endtask

   task automatic settle(input string tag);
      @(posedge clk);
      #2;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s drain: %0d pending, expected 0",
                  tag, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic reset_chk(input string tag);
      chk({tag, " empty"}, 32'(bus.empty), 32'd1);
      chk({tag, " full"}, 32'(bus.full), 32'd0);
      chk({tag, " count"}, 32'(bus.data_count), 32'd0);
      chk({tag, " we"}, 32'(bus.we), 32'd0);
      chk({tag, " d_out"}, bus.d_out, 32'd0);
      chk({tag, " status"},
          32'({bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err}), 32'd0);
   endtask

   task automatic pulse_reset(input bit wr_hold, input string tag);
      @(posedge clk);
      #2;
      bus.wr_en = wr_hold;
      #1;
      reset_n = 1'b0;
      #1;
      reset_chk(tag);
      bus.wr_en = 1'b0;
      #1;
      reset_n = 1'b1;
   endtask

   logic [7:0]  wrap_we [6];
   logic [7:0]  sim_we [3];

   initial begin
      checks = 0;
      errors = 0;
      reset_n = 1'b0;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      d_in = '0;
      for (int i = 0; i < 8; i++) bank[i] = '0;
      wrap_we = '{8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04};
      sim_we  = '{8'h08, 8'h10, 8'h20};

      #3;
      reset_chk("reset");
      #4;
      reset_n = 1'b1;

      for (int i = 0; i < 8; i++)
         op(1, 0, 32'h11 * (i + 1), 8'(1 << i), S_WACK, 0,
            4'(i + 1), "fill");
      op(1, 0, 32'h99, 8'h00, S_WERR, 0, 4'd8, "overflow");

      for (int i = 0; i < 8; i++)
         op(0, 1, 0, 8'h00, S_RACK, 32'h11 * (i + 1),
            4'(7 - i), "drain");
      op(0, 1, 0, 8'h00, S_RERR, 32'h88, 4'd0, "underflow");

      for (int i = 0; i < 5; i++)
         op(1, 0, 32'hA1 + i, 8'(1 << i), S_WACK, 32'h88,
            4'(i + 1), "wrap_w5");
      for (int i = 0; i < 5; i++)
         op(0, 1, 0, 8'h00, S_RACK, 32'hA1 + i, 4'(4 - i), "wrap_r5");
      for (int i = 0; i < 6; i++)
         op(1, 0, 32'hB1 + i, wrap_we[i], S_WACK, 32'hA5,
            4'(i + 1), "wrap_w6");
      for (int i = 0; i < 6; i++)
         op(0, 1, 0, 8'h00, S_RACK, 32'hB1 + i, 4'(5 - i), "wrap_r6");

      for (int i = 0; i < 3; i++)
         op(1, 0, 32'hC1 + i, sim_we[i], S_WACK, 32'hB6,
            4'(i + 1), "sim_w3");
      op(1, 1, 32'hEE, 8'h00, S_NONE, 32'hB6, 4'd3, "simul");
      op(0, 1, 0, 8'h00, S_RACK, 32'hC1, 4'd2, "after_simul");
      settle("simul");

      pulse_reset(1'b0, "rst1");
      for (int i = 0; i < 4; i++)
         op(1, 0, 32'hD1 + i, 8'(1 << i), S_WACK, 0,
            4'(i + 1), "pre_rst");
      settle("pre_rst");

      pulse_reset(1'b1, "midop_rst");
      op(1, 0, 32'hE1, 8'h01, S_WACK, 0, 4'd1, "post_rst_w");
      op(0, 1, 0, 8'h00, S_RACK, 32'hE1, 4'd0, "post_rst_r");
      settle("post_rst");

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
